// File: rtl/aes_192_inv_iter.sv
// Iterative AES-192 inverse cipher, one round per clock.
// Expands the key into a 54-word round-key file (skippable via the key
// cache), then runs INIT + 11 inverse rounds + FINAL in reverse key order.
// Byte 0 sits in the MSBs of state, key and out.
// Ports:
//   clk, rstn      clock; synchronous active-low reset
//   start          request, sampled only in IDLE
//   reuse_key      use the cached schedule instead of expanding key
//   state [127:0]  ciphertext block
//   key   [191:0]  cipher key
//   out   [127:0]  plaintext, registered
//   out_valid      high while out holds the last result
//   busy           high in any state other than IDLE
module aes_192_inv_iter #(
  parameter bit KEY_CACHE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         reuse_key,
  input  logic [127:0] state,
  input  logic [191:0] key,
  output logic [127:0] out,
  output logic         out_valid,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} fsm_t;
  fsm_t fsm, fsm_nxt;

  logic [127:0] ct, s;
  logic [191:0] kreg;
  logic [3:0]   cnt;
  logic         key_cached;
  logic [31:0]  w [54];

  logic         use_cache;
  logic [5:0]   rk_base, wbase;
  logic [127:0] rk, isb, imc_in, rnd_out;
  logic [191:0] kgen;
  logic [31:0]  kt, kw;
  logic [7:0]   rcon, a0, a1, a2, a3;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  assign use_cache = reuse_key && KEY_CACHE_EN && key_cached;

  // Key schedule: kreg holds the previous 6 words; cnt==0 emits the key itself.
  always_comb begin
    rcon = 8'h01 << (cnt - 4'd1);
    kt   = {sbox(kreg[23:16]), sbox(kreg[15:8]), sbox(kreg[7:0]), sbox(kreg[31:24])}
           ^ {rcon, 24'h0};
    kw   = kreg[191:160] ^ kt;
    kgen = '0;
    kgen[191:160] = kw;
    for (int unsigned k = 1; k < 6; k++) begin
      kw = kreg[191 - 32*k -: 32] ^ kw;
      kgen[191 - 32*k -: 32] = kw;
    end
    if (cnt == 4'd0) kgen = kreg;
    wbase = 6'(cnt) * 6'd6;
  end

  // Shared round datapath: ROUND and FINAL both use isb ^ rk.
  always_comb begin
    rk_base = (fsm == INIT) ? 6'd48 : {cnt, 2'b00};
    rk      = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
    isb     = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        isb[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]);
    imc_in  = isb ^ rk;
    rnd_out = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = imc_in[127 - 32*c -: 8];
      a1 = imc_in[119 - 32*c -: 8];
      a2 = imc_in[111 - 32*c -: 8];
      a3 = imc_in[103 - 32*c -: 8];
      rnd_out[127 - 32*c -: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
      rnd_out[119 - 32*c -: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
      rnd_out[111 - 32*c -: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
      rnd_out[103 - 32*c -: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    busy    = (fsm != IDLE);
    unique case (fsm)
      IDLE:    if (start) fsm_nxt = use_cache ? INIT : KEXP;
      KEXP:    if (cnt == 4'd8) fsm_nxt = INIT;
      INIT:    fsm_nxt = ROUND;
      ROUND:   if (cnt == 4'd1) fsm_nxt = FINAL;
      FINAL:   fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out        <= '0;
      out_valid  <= 1'b0;
      key_cached <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE: if (start) begin
          ct        <= state;
          out_valid <= 1'b0;
          cnt       <= '0;
          if (!use_cache) kreg <= key;
        end
        KEXP: begin
          kreg <= kgen;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd8) key_cached <= 1'b1;
        end
        INIT: begin
          s   <= ct ^ rk;
          cnt <= 4'd11;
        end
        ROUND: begin
          s   <= rnd_out;
          cnt <= cnt - 4'd1;
        end
        FINAL: begin
          out       <= imc_in;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && fsm == KEXP)
      for (int unsigned k = 0; k < 6; k++)
        w[wbase + 6'(k)] <= kgen[191 - 32*k -: 32];
  end

endmodule

// File: tb/tb_aes_192_inv_iter.sv
// Bench for aes_192_inv_iter: expected plaintexts come from FIPS-197 C.2
// constants and from a forward AES-192 model (table S-box built by brute-force
// inversion) used to produce ciphertexts for known plaintexts.
module tb_aes_192_inv_iter;

  logic         clk = 1'b0, rstn = 1'b0, start = 1'b0, start0 = 1'b0, reuse_key = 1'b0;
  logic [127:0] state = '0;
  logic [191:0] key = '0;
  logic [127:0] out, out0;
  logic         out_valid, out_valid0, busy, busy0;

  localparam logic [191:0] C2_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] C2_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C2_PT  = 128'h00112233445566778899aabbccddeeff;

  aes_192_inv_iter #(.KEY_CACHE_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .start(start), .reuse_key(reuse_key), .state(state),
    .key(key), .out(out), .out_valid(out_valid), .busy(busy));

  aes_192_inv_iter #(.KEY_CACHE_EN(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .start(start0), .reuse_key(reuse_key), .state(state),
    .key(key), .out(out0), .out_valid(out_valid0), .busy(busy0));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned  total = 0, bad = 0, t0 = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sbt [256];
  logic [191:0] ka;

  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = m_xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] c63 = 8'h63;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] iv, y;
      iv = '0;
      for (int b = 1; b < 256; b++) if (m_mul(8'(a), 8'(b)) == 8'h01) iv = 8'(b);
      for (int i = 0; i < 8; i++)
        y[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c63[i];
      sbt[a] = y;
    end
  endtask

  function automatic logic [127:0] m_enc(input logic [127:0] pt, input logic [191:0] k);
    logic [31:0]  w [52];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] s, t;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = k[191 - 32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      tmp = w[i-1];
      if (i % 6 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = m_xt(rc);
      end
      w[i] = w[i-6] ^ tmp;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 12; r++) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[127 - 8*(rr + 4*c) -: 8] = sbt[s[127 - 8*(rr + 4*((c + rr) % 4)) -: 8]];
      if (r < 12)
        for (int c = 0; c < 4; c++) begin
          a0 = t[127 - 32*c -: 8]; a1 = t[119 - 32*c -: 8];
          a2 = t[111 - 32*c -: 8]; a3 = t[103 - 32*c -: 8];
          t[127 - 32*c -: 8] = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
          t[119 - 32*c -: 8] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
          t[111 - 32*c -: 8] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
          t[103 - 32*c -: 8] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
        end
      s = t ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [191:0] rnd192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at #1 after an edge with the DUT idle; the next edge is E0.
  task automatic issue(input logic [127:0] ct, input logic [191:0] k, input logic ru,
                       input logic [127:0] pt);
    state = ct; key = k; reuse_key = ru; start = 1'b1;
    exp_q.push_back(pt);
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int unsigned bound, output int unsigned lat);
    lat = 999;
    for (int unsigned i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = cyc - t0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    total++; if (out !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid0 got=%b want=0", out_valid0); end
  endtask

  task automatic test_first_reuse();
    int unsigned lat;
    logic [127:0] e;
    issue(C2_CT, C2_KEY, 1'b1, C2_PT);
    wait_valid(40, lat);
    e = exp_q.pop_front();
    total++; if (lat !== 22) begin bad++; $display("FAIL first_reuse_lat got=%0d want=22", lat); end
    total++; if (out !== e) begin bad++; $display("FAIL first_reuse_out got=%h want=%h", out, e); end
  endtask

  task automatic test_fips_c2();
    int unsigned lat;
    logic [127:0] e;
    issue(C2_CT, C2_KEY, 1'b0, C2_PT);
    wait_valid(40, lat);
    e = exp_q.pop_front();
    total++; if (lat !== 22) begin bad++; $display("FAIL c2_lat got=%0d want=22", lat); end
    total++; if (out !== e) begin bad++; $display("FAIL c2_out got=%h want=%h", out, e); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL c2_busy got=%b want=0", busy); end
  endtask

  task automatic test_key_cache();
    int unsigned lat = 999, lat0 = 999;
    logic [127:0] e, o0 = '0;
    state = C2_CT; key = '1; reuse_key = 1'b1; start = 1'b1; start0 = 1'b1;
    exp_q.push_back(C2_PT);
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0; start0 = 1'b0;
    for (int i = 0; i < 40 && (lat == 999 || lat0 == 999); i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 && lat == 999) lat = cyc - t0;
      if (out_valid0 === 1'b1 && lat0 == 999) begin lat0 = cyc - t0; o0 = out0; end
    end
    e = exp_q.pop_front();
    total++; if (lat !== 13) begin bad++; $display("FAIL cache_lat got=%0d want=13", lat); end
    total++; if (out !== e) begin bad++; $display("FAIL cache_out got=%h want=%h", out, e); end
    total++; if (lat0 !== 22) begin bad++; $display("FAIL nocache_lat got=%0d want=22", lat0); end
    total++; if (m_enc(o0, '1) !== C2_CT)
      begin bad++; $display("FAIL nocache_out got=%h (re-encrypts to %h) want ct=%h", o0, m_enc(o0, '1), C2_CT); end
  endtask

  task automatic test_ignore_start();
    logic [127:0] pt, e;
    int unsigned lat;
    logic extra;
    ka = rnd192(); pt = rnd128();
    issue(m_enc(pt, ka), ka, 1'b0, pt);
    while (cyc < t0 + 2) begin @(posedge clk); #1; end
    state = rnd128(); key = ~ka; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < t0 + 9) begin @(posedge clk); #1; end
    state = rnd128(); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid(40, lat);
    e = exp_q.pop_front();
    total++; if (lat !== 22) begin bad++; $display("FAIL ignore_lat got=%0d want=22", lat); end
    total++; if (out !== e) begin bad++; $display("FAIL ignore_out got=%h want=%h", out, e); end
    extra = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || busy !== 1'b0 || out !== e) extra = 1'b1;
    end
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL ignore_second_op got=%b want=0", extra); end
  endtask

  task automatic test_back_to_back(input logic [191:0] k);
    logic [127:0] pts [4];
    logic [127:0] e;
    int unsigned issued, got, last_rise;
    logic prev_v;
    for (int i = 0; i < 4; i++) pts[i] = rnd128();
    reuse_key = 1'b1; key = ~k;
    state = m_enc(pts[0], k); exp_q.push_back(pts[0]); start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; issued = 1; last_rise = t0; got = 0;
    state = m_enc(pts[1], k); exp_q.push_back(pts[1]);
    prev_v = out_valid;
    for (int i = 0; i < 90 && got < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 && prev_v === 1'b0) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++; if (out !== e) begin bad++; $display("FAIL b2b_out%0d got=%h want=%h", got, out, e); end
        total++; if (cyc - last_rise !== (got == 0 ? 13 : 14))
          begin bad++; $display("FAIL b2b_gap%0d got=%0d want=%0d", got, cyc - last_rise, got == 0 ? 13 : 14); end
        got++; last_rise = cyc;
      end
      if (out_valid === 1'b0 && prev_v === 1'b1) begin
        total++; if (cyc - last_rise !== 1)
          begin bad++; $display("FAIL b2b_drop got=%0d want=1", cyc - last_rise); end
        issued++;
        if (issued < 4) begin state = m_enc(pts[issued], k); exp_q.push_back(pts[issued]); end
        else start = 1'b0;
      end
      prev_v = out_valid;
    end
    start = 1'b0;
    total++; if (got !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", got); end
  endtask

  task automatic test_reset_mid_round();
    logic [191:0] kb, kc;
    logic [127:0] pt, e;
    int unsigned lat;
    logic late;
    kb = rnd192(); kc = rnd192(); pt = rnd128();
    issue(m_enc(pt, kb), kb, 1'b0, pt);
    while (cyc < t0 + 14) begin @(posedge clk); #1; end
    rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    exp_q.delete();
    total++; if (out !== '0) begin bad++; $display("FAIL midrst_out got=%h want=0", out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    late = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (out_valid !== 1'b0) late = 1'b1; end
    total++; if (late !== 1'b0) begin bad++; $display("FAIL midrst_late_valid got=%b want=0", late); end
    pt = rnd128();
    issue(m_enc(pt, kc), kc, 1'b1, pt);
    wait_valid(40, lat);
    e = exp_q.pop_front();
    total++; if (lat !== 22) begin bad++; $display("FAIL midrst_next_lat got=%0d want=22", lat); end
    total++; if (out !== e) begin bad++; $display("FAIL midrst_next_out got=%h want=%h", out, e); end
  endtask

  task automatic test_random();
    logic [191:0] k;
    logic [127:0] pt, e;
    int unsigned lat;
    for (int n = 0; n < 3; n++) begin
      k = rnd192(); pt = rnd128();
      issue(m_enc(pt, k), k, 1'b0, pt);
      wait_valid(40, lat);
      e = exp_q.pop_front();
      total++; if (lat !== 22) begin bad++; $display("FAIL rand%0d_exp_lat got=%0d want=22", n, lat); end
      total++; if (out !== e) begin bad++; $display("FAIL rand%0d_exp_out got=%h want=%h", n, out, e); end
      pt = rnd128();
      issue(m_enc(pt, k), ~k, 1'b1, pt);
      wait_valid(40, lat);
      e = exp_q.pop_front();
      total++; if (lat !== 13) begin bad++; $display("FAIL rand%0d_cached_lat got=%0d want=13", n, lat); end
      total++; if (out !== e) begin bad++; $display("FAIL rand%0d_cached_out got=%h want=%h", n, out, e); end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_first_reuse();
    test_fips_c2();
    test_key_cache();
    test_ignore_start();
    test_back_to_back(ka);
    test_reset_mid_round();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_192_inv_iter.md
Name: aes_192_inv_iter

Overview:
- Iterative AES-192 inverse cipher (FIPS-197 decryption) that performs one round per clock.
- It is the decrypt-side counterpart of the pipelined AES-192 encrypt core in the aes_ctr subsystem. It is used wherever the ECB ciphertext must be inverted, e.g. the key-unwrap and self-test paths.
- It expands the key into an internal round-key register file, then runs 12 inverse rounds in reverse key order.
- Byte ordering matches the encrypt core: byte 0 is in the MSBs of state and key.

Parameters:
KEY_CACHE_EN, 1, when 1 the reuse_key input may skip key expansion; when 0 reuse_key is ignored and expansion always runs.

Ports:
clk        in   1    clock
rstn       in   1    reset, synchronous, active-low
start      in   1    request; sampled only in IDLE
reuse_key  in   1    skip expansion and use the cached schedule (valid with start)
state      in   128  ciphertext block; byte0 = [127:120]
key        in   192  cipher key; byte0 = [191:184]
out        out  128  plaintext, registered
out_valid  out  1    level; high while out holds the result of the last request
busy       out  1    high in any state other than IDLE

Behaviour:
- States: IDLE, KEXP, INIT, ROUND, FINAL.
- Reset (rstn=0 at a clk edge): state goes to IDLE, out=0, out_valid=0, busy=0, key_cached=0. The round counter and the round-key file contents are don't-care.
- Reset mid-operation aborts the operation. No out_valid follows it.
- IDLE, start=1 at edge E0:
  - Latch state into the ciphertext register.
  - out_valid goes to 0. out keeps its old value until FINAL.
  - If reuse_key=1, KEY_CACHE_EN=1 and key_cached=1: go to INIT. The key input is ignored.
  - Otherwise: latch key and go to KEXP.
- KEXP (9 cycles, E1..E9):
  - Each cycle produces 6 words w[6i..6i+5], i=0..8, into a 54x32 register file. Words 52 and 53 are unused.
  - w[0..5] = key.
  - For i>=1: t = SubWord(RotWord(w[6i-1])) ^ {rcon[i],24'h0}, with rcon = 01,02,04,08,10,20,40,80. Then w[6i] = w[6i-6]^t and w[6i+k] = w[6i+k-6]^w[6i+k-1] for k=1..5.
  - Uses 4 forward S-box lookups.
  - On E9: key_cached <= 1, go to INIT.
- INIT (1 cycle, E10): s <= ct ^ rk12. Round key r is {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in the MSBs. Set rnd <= 11.
- ROUND (11 cycles, rnd 11 down to 1):
  - s <= InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ rk[rnd]).
  - rnd decrements each cycle. Leave for FINAL after rnd=1.
  - Uses 16 combinational inverse S-box lookups shared with FINAL.
- FINAL (1 cycle):
  - out <= InvSubBytes(InvShiftRows(s)) ^ rk0.
  - out_valid <= 1. Go to IDLE.
- Latency from the accepting edge E0 to out_valid=1:
  - 22 cycles with expansion.
  - 13 cycles with a cached key.
- out_valid and out hold until the next accepted start or reset.
- start while busy=1 is ignored. No queuing occurs and the in-flight operation is not disturbed.
- start held high across the return to IDLE is accepted on the first IDLE cycle. This gives back-to-back operation with 1 IDLE cycle between requests.
- reuse_key=1 with key_cached=0 (after reset) performs a full expansion.
- The cached schedule persists across requests. Only reset or a new expansion changes it.
- All arithmetic is GF(2^8) modulo x^8+x^4+x^3+x+1. InvMixColumns uses the coefficients 0e,0b,0d,09.

Test Plan:
- FIPS-197 C.2: key=000102030405060708090a0b0c0d0e0f1011121314151617, state=dda97ca4864cdfe06eaf70a0ec0d7191, start 1 cycle, reuse_key=0 -> out_valid rises exactly 22 cycles after the accepting edge, out=00112233445566778899aabbccddeeff, busy low on the same cycle.
- Key cache: repeat the same state with reuse_key=1 and key input driven to all-ones -> same plaintext after 13 cycles. With KEY_CACHE_EN=0 -> 22 cycles, and the result is the decryption under the all-ones key.
- reuse_key=1 as the first request after reset with the C.2 key -> 22-cycle latency and the correct plaintext.
- start pulsed at cycles 3 and 10 of an operation with a different state -> ignored; the first result is unchanged and no second out_valid occurs.
- start held high continuously with the cached key -> results every 14 cycles; out_valid drops on each accepting edge.
- rstn low for 1 cycle during ROUND -> out=0, out_valid=0, busy=0 next cycle. No late out_valid. The next request with reuse_key=1 performs a full expansion.
